// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop framing with frame-error flag.
// Data arrives LSB first; each frame is delivered with a one-cycle done pulse.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            frame_error,
    output logic            busy
);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    // state | meaning
    // IDLE  | line idle, waiting for rx_s low
    // START | counting to mid start bit, rejects glitches
    // DATA  | sampling DBIT data bits at mid bit
    // STOP  | waiting out the stop period, then delivering the word
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic            rx_meta, rx_s;
    logic [5:0]      s, s_next;
    logic [NW-1:0]   n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic [DBIT-1:0] dout_next;
    logic            fe_next, done_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            rx_dout      <= '0;
            frame_error  <= 1'b0;
            rx_done_tick <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            s            <= s_next;
            n            <= n_next;
            b            <= b_next;
            rx_dout      <= dout_next;
            frame_error  <= fe_next;
            rx_done_tick <= done_next;
            busy         <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        dout_next  = rx_dout;
        fe_next    = frame_error;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == 6'd7) begin
                        // A high line at mid start bit was only a glitch.
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + 6'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == 6'd15) begin
                        s_next = '0;
                        b_next = {rx_s, b[DBIT-1:1]};
                        if (n == NW'(DBIT - 1)) begin
                            state_next = STOP;
                        end else begin
                            n_next = n + NW'(1);
                        end
                    end else begin
                        s_next = s + 6'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == 6'(SB_TICK - 1)) begin
                        dout_next  = b;
                        fe_next    = ~rx_s;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        s_next = s + 6'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
